conv_row_collector: RTL
=======================

Name: conv_row_collector

Overview:
- Output-side counterpart of the image line-buffer and ping-pong input path.
- Collects the serial FP16 convolution results, one per accepted beat, into full output rows of OUT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 pixels.
- Double-buffers rows in ping/pong banks.
- Presents each completed row as a parallel vector with a valid/ready handshake, mirroring the row-parallel data_in format used on input.

Parameters:
IMAGE_SIZE, 16, input image width/height in pixels
KERNEL_SIZE, 3, convolution kernel edge
DATA_WIDTH, 16, pixel width (FP16: 1 sign, 5 exp, 10 mant)
OUT_SIZE, IMAGE_SIZE-KERNEL_SIZE+1 (14), derived localparam; output row length and row count
IDX_W, $clog2(OUT_SIZE) (4), derived localparam; column/row counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low
frame_start  in  1  starts a frame; clears counters/banks
pix_valid  in  1  convolution result valid
pix_data  in  DATA_WIDTH  convolution result (FP16)
pix_ready  out  1  collector accepts pix_data
row_valid  out  1  completed row available
row_ready  in  1  downstream consumes row
row_data  out  DATA_WIDTH x [0:OUT_SIZE-1]  unpacked row vector, element 0 = leftmost column
row_index  out  IDX_W  output row number of row_data
frame_done  out  1  one-cycle pulse after last row handshake

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; wr_sel=rd_sel=0; col=wr_row=rd_row=0; full[1:0]=0; bank contents=0; frame_done=0. Hence row_valid=0, pix_ready=0, row_index=0, row_data=0. Reset mid-row or mid-frame discards everything.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: pix_ready=0. frame_start -> RUN.
  - RUN: pix_ready = !full[wr_sel]. Accept on pix_valid&&pix_ready: bank[wr_sel][col] <= pix_data; col++.
    - Accept at col==OUT_SIZE-1: full[wr_sel]<=1, wr_sel toggles, col<=0, wr_row++.
    - Accept at col==OUT_SIZE-1 with wr_row==OUT_SIZE-1 -> DRAIN.
  - DRAIN: pix_ready=0. When last row (rd_row==OUT_SIZE-1) handshakes -> IDLE, frame_done=1 for the next cycle only.
- Output side (all states):
  - row_valid = full[rd_sel]; row_data = bank[rd_sel]; row_index = rd_row.
  - On row_valid&&row_ready: full[rd_sel]<=0, rd_sel toggles, rd_row++; wraps to 0 after OUT_SIZE-1.
  - row_data/row_index stay stable while row_valid && !row_ready.
- Latency: last pixel of a row accepted at edge N -> row_valid=1 after edge N (next cycle). Releasing a bank by handshake at edge M -> pix_ready=1 after edge M.
- Simultaneous fill-complete of one bank and drain of the other in the same cycle: both take effect.
- Both banks full: pix_ready=0 and pix_valid is held off without loss.
- frame_start in RUN/DRAIN has top priority: counters, full flags and wr_sel/rd_sel are cleared, any pixel presented that cycle is discarded, state=RUN; row_valid=0 the next cycle. frame_start in the same cycle as a pending frame_done pulse cancels the pulse.
- No arithmetic on data; widths pass through unchanged.
- Counters never exceed OUT_SIZE-1.

Optional Feature:
- CONV_ROW_RELU_EN defined: on capture, pix_data with sign bit set (bit DATA_WIDTH-1) is stored as 16'h0000, including -0.0 and negative NaN. Otherwise it is stored unchanged.
- Undefined: all values stored bit-exact.
- Handshake timing identical in both builds.

Decomposition:
- conv_pkg:
  - typedef fp16_t (logic [15:0]);
  - FP16 field constants EXP_SIZE=5, MANT_SIZE=10;
  - function out_size(img,ker);
  - typedef enum collector_state_t {IDLE, RUN, DRAIN}.
- One natural sub-module: conv_row_bank. One OUT_SIZE x DATA_WIDTH register row with write-enable/column-address port, synchronous clear, parallel read. Instantiated twice (ping/pong).

Test Plan:
- Basic row: reset, frame_start, row_ready=1, 14 beats pix_data=16'h3C00+k -> row_valid 1 cycle after 14th beat; row_data[k]=16'h3C00+k; row_index=0.
- Backpressure: row_ready=0, 30 beats offered -> exactly 28 accepted, pix_ready=0 from beat 29. Set row_ready=1 -> rows 0 then 1 in order with correct data; beat 29 then accepted.
- Full frame: 196 beats, row_ready=1 -> 14 rows with row_index 0..13; frame_done single pulse the cycle after row 13 handshake; state IDLE, pix_ready=0.
- Reset mid-row: rst=0 after 7 accepted beats -> row_valid=0, pix_ready=0. After frame_start, the first row contains only the 14 new values.
- Abort: frame_start with one bank full and pix_valid=1 -> row_valid=0 next cycle; that pixel is not stored; rd_row=0.
- Optional feature: pix_data=16'hBC00 -> row_data element 16'h0000 with CONV_ROW_RELU_EN, 16'hBC00 without; 16'h3C00 unchanged in both builds.

Source files
------------

// File: rtl/conv_row_collector_pkg.sv
// Shared types and helpers for the convolution output row collector.
// Holds the FP16 pixel type, its field sizes, the output-size helper and
// the collector FSM state encoding.
package conv_row_collector_pkg;

   typedef logic [15:0] fp16_t;

   localparam int EXP_SIZE   = 5;
   localparam int MANT_SIZE  = 10;
   localparam int FP16_WIDTH = 1 + EXP_SIZE + MANT_SIZE;

   // A valid (unpadded) convolution shrinks each image edge by KERNEL-1.
   function automatic int out_size(input int img, input int ker);
      return img - ker + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } collector_state_t;

endpackage

// File: rtl/conv_row_collector_if.sv
// Handshake bundle between the convolution engine, the row collector and
// the downstream row consumer. The master drives pixels and consumes rows;
// the slave is the collector itself.
interface conv_row_collector_if #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_SIZE   = 14,
   parameter int IDX_W      = 4
);
   logic                  frame_start;
   logic                  pix_valid;
   logic [DATA_WIDTH-1:0] pix_data;
   logic                  pix_ready;
   logic                  row_valid;
   logic                  row_ready;
   logic [DATA_WIDTH-1:0] row_data [0:OUT_SIZE-1];
   logic [IDX_W-1:0]      row_index;
   logic                  frame_done;

   modport master (
      output frame_start, pix_valid, pix_data, row_ready,
      input  pix_ready, row_valid, row_data, row_index, frame_done
   );

   modport slave (
      input  frame_start, pix_valid, pix_data, row_ready,
      output pix_ready, row_valid, row_data, row_index, frame_done
   );
endinterface

// File: rtl/conv_row_collector_bank.sv
// One row of OUT_SIZE pixel registers: column-addressed write port,
// synchronous clear, whole row readable in parallel.
module conv_row_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_SIZE   = 14,
   parameter int IDX_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_col,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_row [0:OUT_SIZE-1]
);

   logic [DATA_WIDTH-1:0] r_row [0:OUT_SIZE-1];

   // Pixel storage: clear on reset or frame restart, else write one column.
   always_ff @(posedge clk) begin
      for (int i = 0; i < OUT_SIZE; i++) begin
         if (!rst || i_clr) begin
            r_row[i] <= '0;
         end else if (i_we && (i_col == IDX_W'(i))) begin
            r_row[i] <= i_data;
         end
      end
   end

   assign o_row = r_row;

endmodule

// File: rtl/conv_row_collector.sv
// Collects serial FP16 convolution results into full output rows, double
// buffered in ping/pong banks, and presents each completed row as a parallel
// vector with a valid/ready handshake.
// Build option: CONV_ROW_RELU_EN -- when defined, negative-signed pixels
// (sign bit set, including -0.0 and negative NaN) are stored as zero.
//
// state | meaning
// IDLE  | waiting for frame_start, no pixels accepted
// RUN   | filling rows; pixels accepted while the write bank is free
// DRAIN | all rows written, waiting for the last row to be consumed
module conv_row_collector
   import conv_row_collector_pkg::*;
#(
   parameter int IMAGE_SIZE  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int DATA_WIDTH  = 16
) (
   input logic              clk,
   input logic              rst,
   conv_row_collector_if.slave bus
);

   localparam int OUT_SIZE = out_size(IMAGE_SIZE, KERNEL_SIZE);
   localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

   collector_state_t r_state;
   collector_state_t w_state_nxt;

   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [IDX_W-1:0] r_col;
   logic [IDX_W-1:0] r_wr_row;
   logic [IDX_W-1:0] r_rd_row;
   logic [1:0]       r_full;
   logic             r_frame_done;

   logic             w_pix_ready;
   logic             w_accept;
   logic             w_row_done;
   logic             w_row_hs;
   logic             w_last_row_hs;
   logic [DATA_WIDTH-1:0] w_store_data;

   logic [DATA_WIDTH-1:0] w_bank0 [0:OUT_SIZE-1];
   logic [DATA_WIDTH-1:0] w_bank1 [0:OUT_SIZE-1];

   // Pixels are only taken while running and the bank being filled is free.
   // frame_start wins over everything, so it masks both handshakes.
   assign w_pix_ready   = (r_state == RUN) && !r_full[r_wr_sel];
   assign w_accept      = bus.pix_valid && w_pix_ready && !bus.frame_start;
   assign w_row_done    = w_accept && (r_col == LAST_IDX);
   assign w_row_hs      = r_full[r_rd_sel] && bus.row_ready && !bus.frame_start;
   assign w_last_row_hs = w_row_hs && (r_rd_row == LAST_IDX) && (r_state == DRAIN);

`ifdef CONV_ROW_RELU_EN
   assign w_store_data = bus.pix_data[DATA_WIDTH-1] ? '0 : bus.pix_data;
`else
   assign w_store_data = bus.pix_data;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; a restart request overrides the current phase.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.frame_start) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_row_done && (r_wr_row == LAST_IDX)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_last_row_hs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (bus.frame_start) w_state_nxt = RUN;
   end

   // Write/read pointers, bank-full flags and the end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (!rst || bus.frame_start) begin
         r_wr_sel     <= 1'b0;
         r_rd_sel     <= 1'b0;
         r_col        <= '0;
         r_wr_row     <= '0;
         r_rd_row     <= '0;
         r_full       <= 2'b00;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_last_row_hs;
         if (w_accept) begin
            if (r_col == LAST_IDX) begin
               r_col    <= '0;
               r_wr_sel <= ~r_wr_sel;
               r_wr_row <= (r_wr_row == LAST_IDX) ? '0 : r_wr_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_row_hs) begin
            r_rd_sel <= ~r_rd_sel;
            r_rd_row <= (r_rd_row == LAST_IDX) ? '0 : r_rd_row + 1'b1;
         end
         // A completing bank is never full and a draining bank always is,
         // so these two updates never touch the same flag.
         if (w_row_done) r_full[r_wr_sel] <= 1'b1;
         if (w_row_hs)   r_full[r_rd_sel] <= 1'b0;
      end
   end

   conv_row_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_SIZE   (OUT_SIZE),
      .IDX_W      (IDX_W)
   ) u_bank0 (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (bus.frame_start),
      .i_we   (w_accept && !r_wr_sel),
      .i_col  (r_col),
      .i_data (w_store_data),
      .o_row  (w_bank0)
   );

   conv_row_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_SIZE   (OUT_SIZE),
      .IDX_W      (IDX_W)
   ) u_bank1 (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (bus.frame_start),
      .i_we   (w_accept && r_wr_sel),
      .i_col  (r_col),
      .i_data (w_store_data),
      .o_row  (w_bank1)
   );

   // The read-side bank is shown whether or not it is full.
   always_comb begin
      for (int i = 0; i < OUT_SIZE; i++) begin
         bus.row_data[i] = r_rd_sel ? w_bank1[i] : w_bank0[i];
      end
   end

   assign bus.pix_ready  = w_pix_ready;
   assign bus.row_valid  = r_full[r_rd_sel];
   assign bus.row_index  = r_rd_row;
   assign bus.frame_done = r_frame_done;

endmodule
